// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters.
// The granted result is captured in a single back-pressured response register, tagged with the requester index.
module alu_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_op1,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_op2,
    input  logic [NUM_REQ*CTRL_WIDTH-1:0]  req_ctrl,
    output logic [DATA_WIDTH-1:0]          alu_op1,
    output logic [DATA_WIDTH-1:0]          alu_op2,
    output logic [CTRL_WIDTH-1:0]          alu_ctrl,
    input  logic [DATA_WIDTH-1:0]          alu_result,
    input  logic                           alu_eq,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_WIDTH-1:0]            rsp_id,
    output logic [DATA_WIDTH-1:0]          rsp_result,
    output logic                           rsp_eq
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [ID_WIDTH-1:0]     rr_ptr_r;
    logic [ID_WIDTH-1:0]     grant_idx_s;
    logic                    found_s;
    logic                    can_issue_s;
    logic                    grant_s;
    logic [DATA_WIDTH-1:0]   rsp_result_r;
    logic                    rsp_eq_r;
    logic [ID_WIDTH-1:0]     rsp_id_r;

    // Index arithmetic modulo NUM_REQ; works for non-power-of-two requester counts too.
    function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base, input int step);
        int sum_v;
        sum_v = int'(base) + step;
        return ID_WIDTH'(sum_v % NUM_REQ);
    endfunction

    // Round-robin search: scanning offsets from farthest to nearest lets the nearest valid requester win.
    always_comb begin
        found_s     = 1'b0;
        grant_idx_s = {ID_WIDTH{1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            found_s     = found_s | req_valid[wrap_add(rr_ptr_r, k)];
            grant_idx_s = req_valid[wrap_add(rr_ptr_r, k)] ? wrap_add(rr_ptr_r, k) : grant_idx_s;
        end
    end

    assign can_issue_s = rst_n & ((state_r == ST_EMPTY) | rsp_ready);
    assign grant_s     = can_issue_s & found_s;

    // One-hot grant and ALU operand mux; zeros when nothing is granted.
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant_s & (grant_idx_s == ID_WIDTH'(i));
        end
        if (grant_s) begin
            alu_op1  = req_op1[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
            alu_op2  = req_op2[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
            alu_ctrl = req_ctrl[grant_idx_s*CTRL_WIDTH +: CTRL_WIDTH];
        end else begin
            alu_op1  = {DATA_WIDTH{1'b0}};
            alu_op2  = {DATA_WIDTH{1'b0}};
            alu_ctrl = {CTRL_WIDTH{1'b0}};
        end
    end

    // Response-slot next state: a push keeps it full, a pop without push empties it.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_EMPTY: state_next_s = grant_s ? ST_FULL : ST_EMPTY;
            ST_FULL:  state_next_s = (grant_s | ~rsp_ready) ? ST_FULL : ST_EMPTY;
            default:  state_next_s = ST_EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Response payload and round-robin pointer; both move only on a transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_result_r <= {DATA_WIDTH{1'b0}};
            rsp_eq_r     <= 1'b0;
            rsp_id_r     <= {ID_WIDTH{1'b0}};
            rr_ptr_r     <= {ID_WIDTH{1'b0}};
        end else if (grant_s) begin
            rsp_result_r <= alu_result;
            rsp_eq_r     <= alu_eq;
            rsp_id_r     <= grant_idx_s;
            rr_ptr_r     <= wrap_add(grant_idx_s, 1);
        end else begin
            rsp_result_r <= rsp_result_r;
            rsp_eq_r     <= rsp_eq_r;
            rsp_id_r     <= rsp_id_r;
            rr_ptr_r     <= rr_ptr_r;
        end
    end

    assign rsp_valid  = (state_r == ST_FULL);
    assign rsp_id     = rsp_id_r;
    assign rsp_result = rsp_result_r;
    assign rsp_eq     = rsp_eq_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (pending requests, a one-entry response slot and a rotating pointer).
module tb_alu_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int IW = 2;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SEQ = 4'd7;
    localparam logic [3:0] ALU_SLT = 4'd8;
    localparam logic [3:0] ALU_DIV = 4'd9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_op1 = '0;
    logic [N*DW-1:0]   req_op2 = '0;
    logic [N*CW-1:0]   req_ctrl = '0;
    logic [DW-1:0]     alu_op1, alu_op2, alu_result;
    logic [CW-1:0]     alu_ctrl;
    logic              alu_eq;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IW-1:0]     rsp_id;
    logic [DW-1:0]     rsp_result;
    logic              rsp_eq;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_ctrl(req_ctrl),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_eq(alu_eq),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_eq(rsp_eq)
    );

    function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SLL: return a << b[4:0];
            ALU_SRL: return a >> b[4:0];
            ALU_SEQ: return (a == b) ? 32'd1 : 32'd0;
            ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_DIV: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return 32'd0;
        endcase
    endfunction

    // Combinational ALU fixture.
    always_comb begin
        alu_result = alu_fn(alu_ctrl, alu_op1, alu_op2);
        alu_eq     = (alu_op1 == alu_op2);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        req_ctrl[i*CW +: CW] = c;
        req_op1[i*DW +: DW]  = a;
        req_op2[i*DW +: DW]  = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, ALU_ADD, 32'(i), 32'd1);
        for (int c = 0; c < 3; c++) begin
            cyc();
            #4;
            n_cmp++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_id !== 2'd0 || rsp_eq !== 1'b0) begin
                $display("FAIL reset cycle %0d: ready=%b valid=%b result=%0d id=%0d eq=%b, required 0000/0/0/0/0",
                         c, req_ready, rsp_valid, rsp_result, rsp_id, rsp_eq);
                n_fail++;
            end
        end
        req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_add();
        do_reset();
        set_req(2, ALU_ADD, 32'd5, 32'd7);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #4;
        n_cmp++;
        if (req_ready !== 4'b0100 || alu_op1 !== 32'd5 || alu_op2 !== 32'd7 || alu_ctrl !== ALU_ADD) begin
            $display("FAIL single_grant: ready=%b op1=%0d op2=%0d ctrl=%0d, required 0100/5/7/%0d",
                     req_ready, alu_op1, alu_op2, alu_ctrl, ALU_ADD);
            n_fail++;
        end
        cyc();
        req_valid = 4'b0000;
        #4;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'd12 || rsp_id !== 2'd2 || alu_op1 !== 32'd0) begin
            $display("FAIL single_rsp: valid=%b result=%0d id=%0d alu_op1=%0d, required 1/12/2/0",
                     rsp_valid, rsp_result, rsp_id, alu_op1);
            n_fail++;
        end
        cyc();
        #4;
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_result !== 32'd12) begin
            $display("FAIL single_drain: valid=%b result=%0d, required 0/12 (held)", rsp_valid, rsp_result);
            n_fail++;
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, ALU_ADD, 32'(i), 32'd1);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) req_valid = 4'b0000;
            #4;
            if (k < 5) begin
                n_cmp++;
                if (req_ready !== 4'(1 << (k % N))) begin
                    $display("FAIL rr_grant %0d: ready=%b, required %b", k, req_ready, 4'(1 << (k % N)));
                    n_fail++;
                end
            end
            if (k > 0) begin
                n_cmp++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 1) % N) || rsp_result !== 32'(((k - 1) % N) + 1)) begin
                    $display("FAIL rr_rsp %0d: valid=%b id=%0d result=%0d, required 1/%0d/%0d",
                             k, rsp_valid, rsp_id, rsp_result, (k - 1) % N, ((k - 1) % N) + 1);
                    n_fail++;
                end
            end
            cyc();
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        set_req(1, ALU_SEQ, 32'd9, 32'd9);
        set_req(3, ALU_ADD, 32'd3, 32'd4);
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        #4;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            $display("FAIL bp_first_grant: ready=%b, required 0010", req_ready);
            n_fail++;
        end
        cyc();
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #4;
            n_cmp++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_result !== 32'd1 || rsp_eq !== 1'b1 ||
                rsp_id !== 2'd1 || alu_op1 !== 32'd0 || alu_ctrl !== 4'd0) begin
                $display("FAIL bp_hold %0d: ready=%b valid=%b result=%0d eq=%b id=%0d op1=%0d, required 0000/1/1/1/1/0",
                         c, req_ready, rsp_valid, rsp_result, rsp_eq, rsp_id, alu_op1);
                n_fail++;
            end
            cyc();
        end
        rsp_ready = 1'b1;
        #4;
        n_cmp++;
        if (req_ready !== 4'b1000) begin
            $display("FAIL bp_release_grant: ready=%b, required 1000", req_ready);
            n_fail++;
        end
        cyc();
        req_valid = 4'b0000;
        #4;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_result !== 32'd7 || rsp_eq !== 1'b0) begin
            $display("FAIL bp_second_rsp: valid=%b id=%0d result=%0d eq=%b, required 1/3/7/0",
                     rsp_valid, rsp_id, rsp_result, rsp_eq);
            n_fail++;
        end
        cyc();
    endtask

    task automatic test_wrap_skip();
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, ALU_SUB, 32'd100, 32'(i));
        rsp_ready = 1'b1;
        req_valid = 4'b1000;
        #4;
        n_cmp++;
        if (req_ready !== 4'b1000) begin
            $display("FAIL wrap_first: ready=%b, required 1000", req_ready);
            n_fail++;
        end
        cyc();
        req_valid = 4'b0110;
        #4;
        n_cmp++;
        if (req_ready !== 4'b0010 || rsp_id !== 2'd3 || rsp_result !== 32'd97) begin
            $display("FAIL wrap_skip: ready=%b id=%0d result=%0d, required 0010/3/97", req_ready, rsp_id, rsp_result);
            n_fail++;
        end
        cyc();
        req_valid = 4'b0100;
        #4;
        n_cmp++;
        if (req_ready !== 4'b0100 || rsp_id !== 2'd1) begin
            $display("FAIL wrap_next: ready=%b id=%0d, required 0100/1", req_ready, rsp_id);
            n_fail++;
        end
        cyc();
        req_valid = 4'b0000;
        #4;
        n_cmp++;
        if (rsp_id !== 2'd2 || rsp_result !== 32'd98) begin
            $display("FAIL wrap_last_rsp: id=%0d result=%0d, required 2/98", rsp_id, rsp_result);
            n_fail++;
        end
        cyc();
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, ALU_XOR, 32'hF0, 32'(i));
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        cyc();
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        #4;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 32'hF2) begin
            $display("FAIL midrst_full: valid=%b id=%0d result=%h, required 1/2/f2", rsp_valid, rsp_id, rsp_result);
            n_fail++;
        end
        rst_n = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            $display("FAIL midrst_ready_forced: ready=%b, required 0000", req_ready);
            n_fail++;
        end
        cyc();
        rst_n = 1'b1;
        #4;
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || req_ready !== 4'b0001) begin
            $display("FAIL midrst_after: valid=%b result=%0d ready=%b, required 0/0/0001", rsp_valid, rsp_result, req_ready);
            n_fail++;
        end
        cyc();
        req_valid = 4'b0000;
        cyc();
    endtask

    task automatic test_random();
        bit             pend[N];
        logic [3:0]     c_q[N];
        logic [31:0]    a_q[N], b_q[N];
        int             waits[N];
        bit             m_full;
        logic [31:0]    m_res;
        bit             m_eq;
        int             m_id, m_ptr, g;
        logic [N-1:0]   exp_ready;
        logic [31:0]    e_op1, e_op2;
        logic [3:0]     e_ctrl;
        do_reset();
        m_full = 0; m_res = 0; m_eq = 0; m_id = 0; m_ptr = 0;
        for (int i = 0; i < N; i++) begin pend[i] = 0; waits[i] = 0; end
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
                    pend[i] = 1;
                    waits[i] = 0;
                    c_q[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                    a_q[i] = $urandom;
                    b_q[i] = ($urandom_range(0, 3) == 0) ? a_q[i] : (($urandom_range(0, 5) == 0) ? 32'd0 : $urandom);
                    set_req(i, c_q[i], a_q[i], b_q[i]);
                end
                req_valid[i] = pend[i];
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #4;
            n_cmp++;
            if (rsp_valid !== m_full || rsp_result !== m_res || rsp_eq !== m_eq || rsp_id !== 2'(m_id)) begin
                $display("FAIL rand_rsp t=%0d: valid=%b result=%h eq=%b id=%0d, required %b/%h/%b/%0d",
                         t, rsp_valid, rsp_result, rsp_eq, rsp_id, m_full, m_res, m_eq, m_id);
                n_fail++;
            end
            g = -1;
            if (!m_full || rsp_ready) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
            end
            exp_ready = '0;
            e_op1 = 32'd0; e_op2 = 32'd0; e_ctrl = 4'd0;
            if (g >= 0) begin
                exp_ready[g] = 1'b1;
                e_op1 = a_q[g]; e_op2 = b_q[g]; e_ctrl = c_q[g];
            end
            n_cmp++;
            if (req_ready !== exp_ready || alu_op1 !== e_op1 || alu_op2 !== e_op2 || alu_ctrl !== e_ctrl) begin
                $display("FAIL rand_grant t=%0d: ready=%b op1=%h op2=%h ctrl=%0d, required %b/%h/%h/%0d",
                         t, req_ready, alu_op1, alu_op2, alu_ctrl, exp_ready, e_op1, e_op2, e_ctrl);
                n_fail++;
            end
            if (g >= 0) begin
                m_full = 1;
                m_res  = alu_fn(c_q[g], a_q[g], b_q[g]);
                m_eq   = (a_q[g] == b_q[g]);
                m_id   = g;
                m_ptr  = (g + 1) % N;
                pend[g] = 0;
                for (int i = 0; i < N; i++) begin
                    if (pend[i]) waits[i]++;
                end
            end else if (m_full && rsp_ready) begin
                m_full = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (pend[i] && waits[i] >= N) begin
                    n_cmp++;
                    $display("FAIL rand_fairness t=%0d: requester %0d waited %0d transfers, required < %0d", t, i, waits[i], N);
                    n_fail++;
                    waits[i] = 0;
                end
            end
            cyc();
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_round_robin();
        test_back_pressure();
        test_wrap_skip();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
